// File: rtl/cpu_sequencer_pkg.sv
// cpu_sequencer_pkg: shared opcodes, instruction field positions and FSM encoding
package cpu_sequencer_pkg;
  typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_HALT} state_t;
  localparam logic [3:0] OP_LDI = 4'b1000;
  localparam logic [3:0] OP_JMP = 4'b1001;
  localparam logic [3:0] OP_JC  = 4'b1010;
  localparam logic [3:0] OP_JZ  = 4'b1011;
  localparam logic [3:0] OP_HLT = 4'b1111;
  localparam logic [2:0] ALU_OP0 = 3'd0;
  localparam logic [2:0] ALU_OP1 = 3'd1;
  localparam logic [2:0] ALU_OP2 = 3'd2;
  localparam logic [2:0] ALU_OP3 = 3'd3;
  localparam logic [2:0] ALU_OP4 = 3'd4;
  localparam logic [2:0] ALU_OP5 = 3'd5;
  localparam logic [2:0] ALU_OP6 = 3'd6;
  localparam logic [2:0] ALU_OP7 = 3'd7;
  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 10;
  localparam int RS_LSB  = 8;
  localparam int IMM_LSB = 0;
  // the ALU leaves its carry undefined for ops 1, 6 and 7, so CY must not follow it
  function automatic logic cy_defined(input logic [2:0] op);
    case (op)
      ALU_OP1, ALU_OP6, ALU_OP7: return 1'b0;
      ALU_OP0, ALU_OP2, ALU_OP3, ALU_OP4, ALU_OP5: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/cpu_sequencer_regfile.sv
// regfile_4x8: four 8-bit registers, two async read ports, one sync write port
module regfile_4x8 #(
  parameter int NUM_REGS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_ra,
  input  logic [1:0] i_rb,
  input  logic       i_we,
  input  logic [1:0] i_wa,
  input  logic [7:0] i_wd,
  output logic [7:0] o_a,
  output logic [7:0] o_b,
  output logic [7:0] o_r0
);
  logic [7:0] r_mem [NUM_REGS];
  assign o_a  = r_mem[i_ra];
  assign o_b  = r_mem[i_rb];
  assign o_r0 = r_mem[0];
  // register write; reset clears every entry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    else if (i_we)
      r_mem[i_wa] <= i_wd;
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/execute sequencer driving an external 8-bit ALU
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int         NUM_REGS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [7:0]  imem_addr_o,
  input  logic [15:0] imem_data_i,
  input  logic        imem_ack_i,
  output logic [7:0]  alu_a_o,
  output logic [7:0]  alu_b_o,
  output logic [2:0]  alu_op_o,
  input  logic [7:0]  alu_out_i,
  input  logic        alu_cy_i,
  output logic        cy_o,
  output logic        z_o,
  output logic [7:0]  r0_o,
  output logic        halted_o
);
  state_t      r_state;
  logic [7:0]  r_pc;
  logic [15:0] r_ir;
  logic        r_cy, r_z;
  logic [3:0]  w_opc;
  logic [2:0]  w_aop;
  logic [1:0]  w_rd, w_rs;
  logic [7:0]  w_imm, w_a, w_b, w_npc;
  logic        w_exec, w_alu, w_we;
  assign w_opc  = r_ir[OPC_LSB +: 4];
  assign w_aop  = r_ir[OPC_LSB +: 3];
  assign w_rd   = r_ir[RD_LSB +: 2];
  assign w_rs   = r_ir[RS_LSB +: 2];
  assign w_imm  = r_ir[IMM_LSB +: 8];
  assign w_exec = r_state == ST_EXEC;
  assign w_alu  = !w_opc[3];
  assign w_we   = w_exec && (w_alu || w_opc == OP_LDI);
  assign w_npc  = (w_opc == OP_JMP || (w_opc == OP_JC && r_cy) || (w_opc == OP_JZ && r_z)) ? w_imm :
                  w_opc == OP_HLT ? r_pc : r_pc + 8'd1;
  // gating with rst_n drops the request the moment reset is asserted
  assign imem_req_o  = rst_n && r_state == ST_FETCH;
  assign imem_addr_o = r_pc;
  assign alu_a_o     = w_exec ? w_a : '0;
  assign alu_b_o     = w_exec ? w_b : '0;
  assign alu_op_o    = w_exec ? w_aop : '0;
  assign cy_o        = r_cy;
  assign z_o         = r_z;
  assign halted_o    = r_state == ST_HALT;
  regfile_4x8 #(.NUM_REGS(NUM_REGS)) u_rf (
    .clk  (clk),
    .rst_n(rst_n),
    .i_ra (w_rd),
    .i_rb (w_rs),
    .i_we (w_we),
    .i_wa (w_rd),
    .i_wd (w_alu ? alu_out_i : w_imm),
    .o_a  (w_a),
    .o_b  (w_b),
    .o_r0 (r0_o)
  );
  // fetch/execute/halt FSM with PC, IR and flag updates
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_cy    <= 1'b0;
      r_z     <= 1'b0;
    end else
      case (r_state)
        ST_FETCH:
          if (imem_ack_i) begin
            r_ir    <= imem_data_i;
            r_state <= ST_EXEC;
          end
        ST_EXEC: begin
          r_state <= w_opc == OP_HLT ? ST_HALT : ST_FETCH;
          r_pc    <= w_npc;
          if (w_alu) begin
            r_z <= alu_out_i == 8'h00;
            if (cy_defined(w_aop)) r_cy <= alu_cy_i;
          end
        end
        default: r_state <= ST_HALT;
      endcase
endmodule
